// File: rtl/pc_fetch_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer_if
//   REQ/ACK instruction-fetch bus between the fetch sequencer and
//   instruction memory.
//
//   fetch_req   sequencer -> memory  request valid, held until acknowledged
//   fetch_addr  sequencer -> memory  4-bit fetch address (the PC)
//   fetch_ack   memory -> sequencer  request accepted this cycle
//
//   master: the sequencer side. slave: the instruction-memory side.
// ---------------------------------------------------------------------------
interface pc_fetch_sequencer_if;
    logic       fetch_req;
    logic [3:0] fetch_addr;
    logic       fetch_ack;

    modport master (output fetch_req, output fetch_addr, input fetch_ack);
    modport slave  (input fetch_req, input fetch_addr, output fetch_ack);
endinterface

// File: rtl/pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer
//   Program-counter register and fetch sequencer for the 4-bit RISC core.
//   Holds the PC, feeds it to the external incrementor, and issues REQ/ACK
//   fetches. Also handles branch redirects, stalls, halt/resume and
//   wrap-around.
//
//   Optional feature macro: PC_WRAP_TRAP_EN
//     defined   : a PC wrap F->0 by increment halts the core and sets trap
//     undefined : the PC wraps silently and trap is tied to 0
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   fetch      if   fetch bus (master): fetch_req/fetch_addr out, fetch_ack in
//   inc_in     out  incrementor operand, always equal to the PC
//   inc_ou     in   incrementor sum (PC+1)
//   inc_cout   in   incrementor carry-out (1 only when PC = 4'hF)
//   br_valid   in   branch/jump redirect strobe
//   br_target  in   redirect target, valid with br_valid
//   stall      in   downstream stall request
//   halt_in    in   halt request
//   resume     in   leave HALT
//   halted     out  1 while in HALT
//   trap       out  sticky wrap-around trap flag
// ---------------------------------------------------------------------------
module pc_fetch_sequencer #(
    parameter logic [3:0] RESET_ADDR = 4'h0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pc_fetch_sequencer_if.master        fetch,
    output logic [3:0]                  inc_in,
    input  logic [3:0]                  inc_ou,
    input  logic                        inc_cout,
    input  logic                        br_valid,
    input  logic [3:0]                  br_target,
    input  logic                        stall,
    input  logic                        halt_in,
    input  logic                        resume,
    output logic                        halted,
    output logic                        trap
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_STALLED = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    state_t     state;
    logic [3:0] pc;
    logic       br_pend;
    logic [3:0] pend_tgt;
    logic       fetch_req_q;
    logic       halted_q;
    logic [3:0] ack_next_pc;

    // The PC drives both the memory address and the incrementor operand.
    assign fetch.fetch_addr = pc;
    assign inc_in           = pc;
    assign fetch.fetch_req  = fetch_req_q;
    assign halted           = halted_q;

    // PC chosen on an acknowledged fetch: fresh branch, then pending
    // branch, then the incremented value (forced to 0 on carry-out).
    // NOTE: assign a default first in always_comb so no path leaves the
    // output unassigned, which would infer a latch.
    always_comb begin
        ack_next_pc = inc_cout ? 4'h0 : inc_ou;
        if (br_valid) begin
            ack_next_pc = br_target;
        end else if (br_pend) begin
            ack_next_pc = pend_tgt;
        end
    end

`ifdef PC_WRAP_TRAP_EN
    logic trap_q;
    logic is_wrap;

    // Only an increment update counts as wrap; any taken branch does not.
    assign is_wrap = inc_cout && !br_valid && !br_pend;
    assign trap    = trap_q;
`else
    assign trap    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: pend_tgt is qualified by br_pend, but it is reset anyway
            // so the register never carries X into simulation or equivalence.
            state       <= S_IDLE;
            pc          <= RESET_ADDR;
            br_pend     <= 1'b0;
            pend_tgt    <= 4'h0;
            fetch_req_q <= 1'b0;
            halted_q    <= 1'b0;
`ifdef PC_WRAP_TRAP_EN
            trap_q      <= 1'b0;
`endif
        end else begin
            // NOTE: all state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            case (state)
                S_IDLE: begin
                    if (halt_in) begin
                        state       <= S_HALT;
                        halted_q    <= 1'b1;
                        fetch_req_q <= 1'b0;
                    end else begin
                        state       <= S_FETCH;
                        fetch_req_q <= 1'b1;
                    end
                end

                S_FETCH: begin
                    if (!fetch.fetch_ack) begin
                        // Request held; remember the most recent redirect.
                        if (br_valid) begin
                            br_pend  <= 1'b1;
                            pend_tgt <= br_target;
                        end
                    end else begin
                        pc      <= ack_next_pc;
                        br_pend <= 1'b0;
`ifdef PC_WRAP_TRAP_EN
                        if (is_wrap) begin
                            state       <= S_HALT;
                            halted_q    <= 1'b1;
                            fetch_req_q <= 1'b0;
                            trap_q      <= 1'b1;
                        end else
`endif
                        if (halt_in) begin
                            state       <= S_HALT;
                            halted_q    <= 1'b1;
                            fetch_req_q <= 1'b0;
                        end else if (stall) begin
                            state       <= S_STALLED;
                            fetch_req_q <= 1'b0;
                        end else begin
                            state       <= S_FETCH;
                            fetch_req_q <= 1'b1;
                        end
                    end
                end

                S_STALLED: begin
                    if (br_valid) begin
                        pc      <= br_target;
                        br_pend <= 1'b0;
                    end
                    if (halt_in) begin
                        state    <= S_HALT;
                        halted_q <= 1'b1;
                    end else if (!stall) begin
                        state       <= S_FETCH;
                        fetch_req_q <= 1'b1;
                    end
                end

                S_HALT: begin
                    if (br_valid) begin
                        pc <= br_target;
                    end
                    // halt_in keeps the core parked even if resume is high.
                    if (!halt_in && resume) begin
                        state       <= S_FETCH;
                        halted_q    <= 1'b0;
                        fetch_req_q <= 1'b1;
`ifdef PC_WRAP_TRAP_EN
                        trap_q      <= 1'b0;
`endif
                    end
                end

                default: begin
                    state       <= S_IDLE;
                    fetch_req_q <= 1'b0;
                    halted_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_sequencer
//   Directed bench for pc_fetch_sequencer. Inputs change 1 ns after each
//   rising edge; outputs are sampled at that same point, well clear of the
//   edge. The incrementor is modelled here as PC+1 with carry at 4'hF.
// ---------------------------------------------------------------------------
module tb_pc_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] inc_in;
    logic [3:0] inc_ou;
    logic       inc_cout;
    logic       br_valid;
    logic [3:0] br_target;
    logic       stall;
    logic       halt_in;
    logic       resume;
    logic       halted;
    logic       trap;

    int checks = 0;
    int errors = 0;

    pc_fetch_sequencer_if fetch_bus ();

    pc_fetch_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fetch     (fetch_bus),
        .inc_in    (inc_in),
        .inc_ou    (inc_ou),
        .inc_cout  (inc_cout),
        .br_valid  (br_valid),
        .br_target (br_target),
        .stall     (stall),
        .halt_in   (halt_in),
        .resume    (resume),
        .halted    (halted),
        .trap      (trap)
    );

    always #5 clk = ~clk;

    assign inc_ou   = inc_in + 4'h1;
    assign inc_cout = (inc_in == 4'hF);

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic req, input logic [3:0] addr,
                              input logic hlt, input logic trp);
        check({tag, ".req"},    {3'b0, fetch_bus.fetch_req}, {3'b0, req});
        check({tag, ".addr"},   fetch_bus.fetch_addr, addr);
        check({tag, ".halted"}, {3'b0, halted}, {3'b0, hlt});
        check({tag, ".trap"},   {3'b0, trap}, {3'b0, trp});
    endtask

    initial begin
        rst_n     = 1'b0;
        fetch_bus.fetch_ack = 1'b1;
        br_valid  = 1'b0;
        br_target = 4'h0;
        stall     = 1'b0;
        halt_in   = 1'b0;
        resume    = 1'b0;

        step();
        step();
        expect_out("reset", 1'b0, 4'h0, 1'b0, 1'b0);
        check("inc_in_reset", inc_in, 4'h0);
        rst_n = 1'b1;

        // First post-reset edge raises the request at RESET_ADDR.
        step();
        expect_out("first_req", 1'b1, 4'h0, 1'b0, 1'b0);

        // ACK tied high: one fetch per cycle, 1..F.
        for (int i = 1; i < 16; i++) begin
            step();
            check($sformatf("seq_%0d", i), fetch_bus.fetch_addr, i[3:0]);
            check($sformatf("seq_req_%0d", i), {3'b0, fetch_bus.fetch_req}, 4'h1);
        end

        // Wrap from F.
        step();
`ifdef PC_WRAP_TRAP_EN
        expect_out("wrap_trap", 1'b0, 4'h0, 1'b1, 1'b1);
        resume = 1'b1;
        step();
        resume = 1'b0;
        expect_out("wrap_resume", 1'b1, 4'h0, 1'b0, 1'b0);
`else
        expect_out("wrap_silent", 1'b1, 4'h0, 1'b0, 1'b0);
`endif

        // Advance to PC=3, then a branch during an ACK wait.
        step(); step(); step();
        check("at_3", fetch_bus.fetch_addr, 4'h3);
        fetch_bus.fetch_ack = 1'b0;
        br_valid  = 1'b1;
        br_target = 4'hA;
        step();
        expect_out("wait1", 1'b1, 4'h3, 1'b0, 1'b0);
        br_valid = 1'b0;
        step();
        expect_out("wait2", 1'b1, 4'h3, 1'b0, 1'b0);
        fetch_bus.fetch_ack = 1'b1;
        step();
        check("pend_branch", fetch_bus.fetch_addr, 4'hA);

        // Branches taken with ACK: A->5, then 5->9, then 9->4.
        br_valid  = 1'b1;
        br_target = 4'h5;
        step();
        check("br_to_5", fetch_bus.fetch_addr, 4'h5);
        br_target = 4'h9;
        step();
        check("br_ack_9", fetch_bus.fetch_addr, 4'h9);
        br_target = 4'h4;
        step();
        check("br_to_4", fetch_bus.fetch_addr, 4'h4);
        br_valid = 1'b0;

        // Stall with ACK at PC=4.
        stall = 1'b1;
        step();
        expect_out("stall1", 1'b0, 4'h5, 1'b0, 1'b0);
        step();
        expect_out("stall2", 1'b0, 4'h5, 1'b0, 1'b0);
        stall = 1'b0;
        step();
        expect_out("unstall", 1'b1, 4'h5, 1'b0, 1'b0);

        // Halt with ACK at PC=7.
        step(); step();
        check("at_7", fetch_bus.fetch_addr, 4'h7);
        halt_in = 1'b1;
        step();
        expect_out("halt", 1'b0, 4'h8, 1'b1, 1'b0);
        halt_in = 1'b0;
        step();
        expect_out("halt_hold", 1'b0, 4'h8, 1'b1, 1'b0);
        resume = 1'b1;
        step();
        resume = 1'b0;
        expect_out("resume", 1'b1, 4'h8, 1'b0, 1'b0);

        // Halt again; halt_in beats resume, and a branch in HALT loads PC.
        halt_in = 1'b1;
        step();
        expect_out("halt2", 1'b0, 4'h9, 1'b1, 1'b0);
        resume    = 1'b1;
        br_valid  = 1'b1;
        br_target = 4'h6;
        step();
        expect_out("halt_prio", 1'b0, 4'h6, 1'b1, 1'b0);
        halt_in  = 1'b0;
        br_valid = 1'b0;
        step();
        resume = 1'b0;
        expect_out("resume2", 1'b1, 4'h6, 1'b0, 1'b0);

        // Pending branch at PC=6, then async reset mid-request.
        fetch_bus.fetch_ack = 1'b0;
        br_valid  = 1'b1;
        br_target = 4'hC;
        step();
        br_valid = 1'b0;
        check("pend_6", fetch_bus.fetch_addr, 4'h6);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_rst", 1'b0, 4'h0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        fetch_bus.fetch_ack = 1'b1;
        step();
        expect_out("restart", 1'b1, 4'h0, 1'b0, 1'b0);
        step();
        check("no_redirect", fetch_bus.fetch_addr, 4'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Program-counter register and fetch sequencer for the 4-bit RISC core. It holds the 4-bit PC and drives it into the 4-bit incrementor. It takes the incremented value and carry-out back, and issues REQ/ACK instruction-fetch requests to instruction memory. It also handles branch redirects, pipeline stalls, halt/resume and optional wrap-around trapping.

## Interface
- RESET_ADDR, 4'h0, PC value loaded on reset.
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- INC_IN  out  4  operand to the incrementor; always equals the PC register.
- INC_OU  in  4  incrementor sum (PC+1), combinational from INC_IN.
- INC_COUT  in  1  incrementor carry-out; 1 only when PC=4'hF.
- FETCH_REQ  out  1  fetch request to instruction memory.
- FETCH_ADDR  out  4  fetch address; always equals the PC register.
- FETCH_ACK  in  1  memory accepted the request this cycle.
- BR_VALID  in  1  branch/jump redirect strobe.
- BR_TARGET  in  4  redirect target, valid with BR_VALID.
- STALL  in  1  downstream stall request.
- HALT_IN  in  1  halt request.
- RESUME  in  1  leave HALT.
- HALTED  out  1  1 while in HALT.
- TRAP  out  1  sticky wrap-around trap flag.

## Operation
- States: IDLE, FETCH, STALLED, HALT. Encoding is free.
- Registers: PC[3:0], BR_PEND (1 bit), PEND_TGT[3:0], TRAP.
- Reset (RST_N=0, async):
  - state=IDLE, PC=RESET_ADDR, BR_PEND=0, TRAP=0.
  - FETCH_REQ=0, HALTED=0.
- IDLE (FETCH_REQ=0):
  - HALT_IN=1 -> HALT.
  - Otherwise -> FETCH.
- FETCH (FETCH_REQ=1): the request is held with FETCH_ADDR stable until FETCH_ACK.
  - ACK=0: PC holds. STALL and HALT_IN are ignored. BR_VALID=1 sets BR_PEND=1 and PEND_TGT=BR_TARGET; a later BR_VALID overwrites PEND_TGT.
  - ACK=1: PC updates. Next-PC priority is BR_TARGET (if BR_VALID this cycle), then PEND_TGT (if BR_PEND), then INC_OU. BR_PEND clears.
  - ACK=1, next state: HALT_IN -> HALT; else STALL -> STALLED; else stay in FETCH (back-to-back fetch).
- STALLED (FETCH_REQ=0):
  - BR_VALID loads PC=BR_TARGET directly and clears BR_PEND.
  - HALT_IN -> HALT; else STALL=0 -> FETCH.
- HALT (HALTED=1, FETCH_REQ=0):
  - PC holds. BR_VALID loads PC=BR_TARGET.
  - RESUME -> FETCH and clears TRAP. HALT_IN has priority over RESUME when both are high.
- Wrap-around: an increment update with INC_COUT=1 loads PC=4'h0; see Configuration. A taken branch never counts as wrap.

## Timing
- All outputs are registered state or direct decodes of state/PC. There are no combinational paths from inputs to outputs.
- The incrementor path (INC_IN -> INC_OU/INC_COUT) is combinational within one cycle and is sampled at the ACK edge.
- First FETCH_REQ=1 appears after the first rising CLK edge following RST_N release.
- Throughput: one fetch per cycle with ACK held high. PC after an ACK edge is the next FETCH_ADDR in the same cycle.
- Redirect latency: a branch seen with ACK, or while STALLED/HALT, makes BR_TARGET the very next FETCH_ADDR.
- Reset asserted mid-request drops FETCH_REQ immediately (async) and discards any pending branch.

## Configuration
- PC_WRAP_TRAP_EN defined: on a wrap update, PC=4'h0, state -> HALT and TRAP=1. This overrides STALL/HALT_IN routing. TRAP holds until RESUME or reset.
- PC_WRAP_TRAP_EN undefined: PC wraps silently 4'hF -> 4'h0, fetching continues, and TRAP is constant 0.

## Test plan
- Reset release, ACK tied 1: FETCH_ADDR sequence is 0,1,2,...,F across consecutive cycles, with FETCH_REQ=1 from the first post-reset edge.
- Branch timing at PC=3: ACK held low 2 cycles with BR_VALID/BR_TARGET=A in the first, then ACK=1 -> FETCH_ADDR stays 3 throughout wait, next address A. BR_VALID with ACK at PC=5, target 9 -> next address 9.
- STALL with ACK at PC=4 -> FETCH_REQ=0, PC=5 held while STALL=1. STALL drops -> FETCH_REQ=1, address 5.
- HALT_IN with ACK at PC=7 -> HALTED=1, PC=8. RESUME -> FETCH_ADDR=8, HALTED=0.
- PC=F, ACK=1, no branch: with PC_WRAP_TRAP_EN, PC=0, TRAP=1, HALTED=1, and RESUME clears TRAP. Without it, FETCH_ADDR=0 and fetch continues with TRAP=0.
- RST_N pulsed low mid-request at PC=6 with BR_PEND set -> outputs reset immediately. After release, fetch restarts at RESET_ADDR with no redirect.
